// File: rtl/crc16_txappend.sv
// -----------------------------------------------------------------------------
// crc16_txappend
//
// Transmit-path stage that sits between the EPC bit generator and the
// backscatter encoder. It pulls one data bit per link-rate strobe, passes
// each bit through, and then appends the Gen2 CRC-16. The CRC uses polynomial
// 0x1021 and preset 0xFFFF. The CRC is sent ones-complemented, MSB first.
//
// Optional feature (compile-time macro CRC16_TRAILER_BIT_EN):
//   When the macro is defined, one dummy '1' bit is sent after the 16th CRC
//   bit, and completion follows on the next strobe.
//   When the macro is undefined, completion follows the last CRC bit directly.
//
// Parameters:
//   MAXBITS       data-bit limit per reply; reaching it without lastbit
//                 forces the CRC phase and raises overflow
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   start         one-cycle pulse, begin (or abort and restart) a reply
//   bitstrobe     one-cycle link-rate tick, one output bit per tick
//   bitin         current upstream data bit
//   lastbit       upstream is presenting its final data bit
//   bitadv        one-cycle pulse, upstream advances to its next bit
//   bitout        reply bit to the encoder
//   bitout_valid  bitout holds a reply bit
//   txdone        reply complete, held until the next start
//   overflow      MAXBITS reached without lastbit, held until the next start
//   crc_out       running CRC register (debug)
// -----------------------------------------------------------------------------
module crc16_txappend #(
  parameter int MAXBITS = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        bitstrobe,
  input  logic        bitin,
  input  logic        lastbit,
  output logic        bitadv,
  output logic        bitout,
  output logic        bitout_valid,
  output logic        txdone,
  output logic        overflow,
  output logic [15:0] crc_out
);

  localparam logic [15:0] CRC_POLY   = 16'h1021;
  localparam logic [15:0] CRC_PRESET = 16'hFFFF;
  localparam logic [8:0]  MAXBITS_W  = 9'(MAXBITS);

  // S_FIN means the last reply bit is on the wire.
  // The next strobe in S_FIN is the completion strobe.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DATA  = 3'd1,
    S_CRC   = 3'd2,
    S_FIN   = 3'd3,
    S_DONE  = 3'd4
`ifdef CRC16_TRAILER_BIT_EN
    , S_TRAIL = 3'd5
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic        bitout_q, bitout_d;
  logic        valid_q, valid_d;
  logic        bitadv_q, bitadv_d;
  logic        txdone_q, txdone_d;
  logic        overflow_q, overflow_d;

  logic [8:0]  cnt_inc;
  logic        fb;

  assign cnt_inc = {1'b0, cnt_q} + 9'd1;
  assign fb      = crc_q[15] ^ bitin;

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    bitout_d   = bitout_q;
    valid_d    = valid_q;
    bitadv_d   = 1'b0;        // bitadv is a pulse, so its default is low
    txdone_d   = txdone_q;
    overflow_d = overflow_q;

    if (start) begin
      // start outranks a coincident strobe; any reply in flight is dropped
      state_d    = S_DATA;
      crc_d      = CRC_PRESET;
      cnt_d      = 8'd0;
      txdone_d   = 1'b0;
      overflow_d = 1'b0;
      valid_d    = 1'b0;
    end else if (bitstrobe) begin
      case (state_q)
        S_DATA: begin
          bitout_d = bitin;
          valid_d  = 1'b1;
          crc_d    = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
          cnt_d    = cnt_inc[7:0];
          if (lastbit) begin
            state_d = S_CRC;
            idx_d   = 4'd15;
          end else if (cnt_inc == MAXBITS_W) begin
            state_d    = S_CRC;
            idx_d      = 4'd15;
            overflow_d = 1'b1;
          end else begin
            bitadv_d = 1'b1;
          end
        end
        S_CRC: begin
          // Shifting the register out with zero fill sends the CRC MSB first.
          bitout_d = ~crc_q[15];
          crc_d    = {crc_q[14:0], 1'b0};
          idx_d    = idx_q - 4'd1;
          if (idx_q == 4'd0) begin
`ifdef CRC16_TRAILER_BIT_EN
            state_d = S_TRAIL;
`else
            state_d = S_FIN;
`endif
          end
        end
`ifdef CRC16_TRAILER_BIT_EN
        S_TRAIL: begin
          bitout_d = 1'b1;
          state_d  = S_FIN;
        end
`endif
        S_FIN: begin
          bitout_d = 1'b0;
          valid_d  = 1'b0;
          txdone_d = 1'b1;
          state_d  = S_DONE;
        end
        default: ;  // IDLE and DONE ignore strobes
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      crc_q      <= CRC_PRESET;
      cnt_q      <= 8'd0;
      idx_q      <= 4'd0;
      bitout_q   <= 1'b0;
      valid_q    <= 1'b0;
      bitadv_q   <= 1'b0;
      txdone_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      bitout_q   <= bitout_d;
      valid_q    <= valid_d;
      bitadv_q   <= bitadv_d;
      txdone_q   <= txdone_d;
      overflow_q <= overflow_d;
    end
  end

  assign bitadv       = bitadv_q;
  assign bitout       = bitout_q;
  assign bitout_valid = valid_q;
  assign txdone       = txdone_q;
  assign overflow     = overflow_q;
  assign crc_out      = crc_q;

endmodule

// File: tb/tb_crc16_txappend.sv
// -----------------------------------------------------------------------------
// tb_crc16_txappend
//
// Directed bench for crc16_txappend. A small upstream model supplies data bits
// and advances only on bitadv. Every reply is walked strobe by strobe, and the
// pass-through bits, CRC bits, bitadv pulses and completion flags are checked
// against hand-computed constants.
// Honors CRC16_TRAILER_BIT_EN to expect the extra trailer bit.
// -----------------------------------------------------------------------------
module tb_crc16_txappend;

`ifdef CRC16_TRAILER_BIT_EN
  localparam int TRAIL_BITS = 1;
`else
  localparam int TRAIL_BITS = 0;
`endif

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        bitstrobe;
  logic        bitin;
  logic        lastbit;
  logic        bitadv;
  logic        bitout;
  logic        bitout_valid;
  logic        txdone;
  logic        overflow;
  logic [15:0] crc_out;

  int n_tests;
  int n_fail;

  // upstream model state
  logic [255:0] dv;
  int           n_bits;
  bit           last_en;
  int           ptr;

  crc16_txappend #(.MAXBITS(128)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .bitstrobe    (bitstrobe),
    .bitin        (bitin),
    .lastbit      (lastbit),
    .bitadv       (bitadv),
    .bitout       (bitout),
    .bitout_valid (bitout_valid),
    .txdone       (txdone),
    .overflow     (overflow),
    .crc_out      (crc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // drive the current upstream bit
  task automatic present();
    bitin   = dv[255 - ptr];
    lastbit = last_en && (ptr == n_bits - 1);
  endtask

  // one strobe cycle; returns at the negedge after the sampling edge
  task automatic strobe_once();
    @(negedge clk);
    bitstrobe = 1'b1;
    @(negedge clk);
    bitstrobe = 1'b0;
  endtask

  task automatic pulse_start(input bit with_strobe);
    @(negedge clk);
    start     = 1'b1;
    bitstrobe = with_strobe;
    @(negedge clk);
    start     = 1'b0;
    bitstrobe = 1'b0;
  endtask

  // feed one bit into a serial Gen2 CRC (used for the residue check)
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic f;
    f = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
  endfunction

  task automatic run_reply(input string name, input logic [255:0] data, input int n,
                           input bit use_last, input bit chk_crc, input logic [15:0] exp_crc,
                           input bit exp_ovf, input bit coinc, input bit do_start);
    int          adv_cnt;
    logic [15:0] res;
    dv      = data;
    n_bits  = n;
    last_en = use_last;
    ptr     = 0;
    present();
    if (do_start) begin
      pulse_start(coinc);
      check({name, "_start_valid"}, 32'(bitout_valid), 32'd0);
      check({name, "_start_adv"},   32'(bitadv),       32'd0);
      check({name, "_start_crc"},   32'(crc_out),      32'hFFFF);
    end
    check({name, "_start_done"}, 32'(txdone),   32'd0);
    check({name, "_start_ovf"},  32'(overflow), 32'd0);
    adv_cnt = 0;
    res     = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      strobe_once();
      check({name, "_data_bit"},   32'(bitout),       32'(data[255 - k]));
      check({name, "_data_valid"}, 32'(bitout_valid), 32'd1);
      check({name, "_data_adv"},   32'(bitadv),       32'(k < n - 1));
      res = crc_step(res, bitout);
      if (bitadv) begin
        adv_cnt++;
        if (ptr < 255) ptr++;
        present();
      end
    end
    for (int j = 0; j < 16; j++) begin
      strobe_once();
      check({name, "_crc_valid"}, 32'(bitout_valid), 32'd1);
      check({name, "_crc_adv"},   32'(bitadv),       32'd0);
      check({name, "_crc_done"},  32'(txdone),       32'd0);
      if (chk_crc) check({name, "_crc_bit"}, 32'(bitout), 32'(exp_crc[15 - j]));
      res = crc_step(res, bitout);
    end
    for (int t = 0; t < TRAIL_BITS; t++) begin
      strobe_once();
      check({name, "_trail_bit"},   32'(bitout),       32'd1);
      check({name, "_trail_valid"}, 32'(bitout_valid), 32'd1);
      check({name, "_trail_done"},  32'(txdone),       32'd0);
    end
    strobe_once();
    check({name, "_end_valid"}, 32'(bitout_valid), 32'd0);
    check({name, "_end_bit"},   32'(bitout),       32'd0);
    check({name, "_end_done"},  32'(txdone),       32'd1);
    check({name, "_end_ovf"},   32'(overflow),     32'(exp_ovf));
    check({name, "_end_crc"},   32'(crc_out),      32'h0000);
    check({name, "_adv_count"}, 32'(adv_cnt),      32'(n - 1));
    if (!chk_crc) check({name, "_residue"}, 32'(res), 32'h1D0F);
    // Strobes in DONE are ignored and the outputs hold.
    strobe_once();
    check({name, "_hold_done"},  32'(txdone),       32'd1);
    check({name, "_hold_valid"}, 32'(bitout_valid), 32'd0);
    $display("[TB] reply %s: %0d data bits, %0d bitadv, overflow=%0b", name, n, adv_cnt, overflow);
  endtask

  logic [255:0] d_ascii;
  logic [255:0] d_zero;
  logic [255:0] d_one;
  logic [255:0] d_ovf;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    bitstrobe = 1'b0;
    bitin     = 1'b0;
    lastbit   = 1'b0;
    dv        = '0;
    n_bits    = 1;
    last_en   = 1'b0;
    ptr       = 0;

    d_ascii = {72'h313233343536373839, 184'd0};
    d_zero  = {1'b0, 255'd0};
    d_one   = {1'b1, 255'd0};
    d_ovf   = '0;
    for (int i = 0; i < 128; i++) d_ovf[255 - i] = ((i % 3) == 0) ^ ((i >> 4) & 1);

    repeat (3) @(negedge clk);
    check("rst_crc",    32'(crc_out),      32'hFFFF);
    check("rst_valid",  32'(bitout_valid), 32'd0);
    check("rst_bit",    32'(bitout),       32'd0);
    check("rst_adv",    32'(bitadv),       32'd0);
    check("rst_done",   32'(txdone),       32'd0);
    check("rst_ovf",    32'(overflow),     32'd0);
    reset_n = 1'b1;
    $display("[TB] reset state checked");

    // Strobes in IDLE are ignored.
    strobe_once();
    check("idle_valid", 32'(bitout_valid), 32'd0);
    check("idle_crc",   32'(crc_out),      32'hFFFF);

    run_reply("ascii", d_ascii, 72, 1'b1, 1'b1, 16'hD64E, 1'b0, 1'b0, 1'b1);
    run_reply("bit0",  d_zero,  1,  1'b1, 1'b1, 16'h1020, 1'b0, 1'b0, 1'b1);
    run_reply("ovf",   d_ovf,   128, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Abort a reply at data bit 40 and then restart it.
    dv = d_ascii; n_bits = 72; last_en = 1'b1; ptr = 0; present();
    pulse_start(1'b0);
    for (int k = 0; k < 40; k++) begin
      strobe_once();
      if (bitadv) begin
        ptr++;
        present();
      end
    end
    check("abort_pre_valid", 32'(bitout_valid), 32'd1);
    pulse_start(1'b0);
    check("abort_valid", 32'(bitout_valid), 32'd0);
    check("abort_crc",   32'(crc_out),      32'hFFFF);
    check("abort_ovf",   32'(overflow),     32'd0);
    check("abort_done",  32'(txdone),       32'd0);
    $display("[TB] reply aborted at data bit 40");
    run_reply("restart", d_ascii, 72, 1'b1, 1'b1, 16'hD64E, 1'b0, 1'b0, 1'b0);

    // start coincident with a strobe: that strobe is dropped
    run_reply("coinc", d_one, 1, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b1);

    // Pulse an async reset in the CRC phase, between clock edges.
    dv = d_zero; n_bits = 1; last_en = 1'b1; ptr = 0; present();
    pulse_start(1'b0);
    repeat (6) strobe_once();
    check("pre_rst_valid", 32'(bitout_valid), 32'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(bitout_valid), 32'd0);
    check("arst_bit",   32'(bitout),       32'd0);
    check("arst_adv",   32'(bitadv),       32'd0);
    check("arst_done",  32'(txdone),       32'd0);
    check("arst_ovf",   32'(overflow),     32'd0);
    check("arst_crc",   32'(crc_out),      32'hFFFF);
    #1 reset_n = 1'b1;
    $display("[TB] async reset mid-CRC checked");
    for (int s = 0; s < 3; s++) begin
      strobe_once();
      check("post_rst_valid", 32'(bitout_valid), 32'd0);
      check("post_rst_adv",   32'(bitadv),       32'd0);
      check("post_rst_crc",   32'(crc_out),      32'hFFFF);
    end
    run_reply("after_rst", d_one, 1, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
